// File: rtl/am_pkg.sv
// Shared definitions for the AM normalizer: lane-mode encodings, FSM states
// and the bitnum decode used at operand capture.
package am_pkg;

    localparam int DATA_W = 16;

    // Lane-mode encodings as they appear on bitnum; 01 and 11 both select one
    // 16-bit lane and are folded onto LANE16 by decode_mode().
    typedef enum logic [1:0] {
        LANE4  = 2'b00,
        LANE16 = 2'b01,
        LANE8  = 2'b10
    } lane_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic lane_mode_e decode_mode(input logic [1:0] bitnum);
        case (bitnum)
            2'b00:   return LANE4;
            2'b10:   return LANE8;
            default: return LANE16;
        endcase
    endfunction

endpackage

// File: rtl/am_lane_done.sv
// Per-lane "normalized" detection. A lane is done once its top two bits
// differ or its shift count has reached lane width - 1. Mask bits that do not
// correspond to a lane in the current mode read as 1, so &done_mask_o means
// "every lane is finished".
import am_pkg::*;

module am_lane_done (
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] cnt_i,
    input  lane_mode_e        mode_i,
    output logic [3:0]        done_mask_o
);

    // Done mask derived from the registered lane values and counts.
    always_comb begin
        done_mask_o = 4'b1111;
        case (mode_i)
            LANE4: begin
                for (int i = 0; i < 4; i++) begin
                    done_mask_o[i] = (data_i[4*i+3] != data_i[4*i+2]) ||
                                     (cnt_i[4*i +: 4] == 4'd3);
                end
            end
            LANE8: begin
                for (int i = 0; i < 2; i++) begin
                    done_mask_o[i] = (data_i[8*i+7] != data_i[8*i+6]) ||
                                     (cnt_i[8*i +: 8] == 8'd7);
                end
            end
            default: begin
                done_mask_o[0] = (data_i[15] != data_i[14]) ||
                                 (cnt_i == 16'd15);
            end
        endcase
    end

endmodule

// File: rtl/am_normalizer.sv
// Lane-packed signed normalizer. Each lane is shifted left one bit per cycle
// (zero fill, no carry across lanes) until it is normalized or saturated at
// width - 1 shifts; the per-lane shift count is reported alongside.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for an operand; in_ready high
// ST_SHIFT | evaluate done mask; shift/count unfinished lanes or finish
// ST_DONE  | result held on dataout/shcnt with out_valid until out_ready
import am_pkg::*;

module am_normalizer (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] datain,
    input  logic [1:0]        bitnum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dataout,
    output logic [DATA_W-1:0] shcnt,
    output logic              busy
);

    state_e            state_q, state_d;
    lane_mode_e        mode_q, mode_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [3:0]        done_mask;
    logic              all_done;
    logic [DATA_W-1:0] shift_data;
    logic [DATA_W-1:0] shift_cnt;

    am_lane_done u_lane_done (
        .data_i      (data_q),
        .cnt_i       (cnt_q),
        .mode_i      (mode_q),
        .done_mask_o (done_mask)
    );

    assign all_done = &done_mask;

    // One shift step: advance every lane that is not yet done, hold the rest.
    always_comb begin
        shift_data = data_q;
        shift_cnt  = cnt_q;
        case (mode_q)
            LANE4: begin
                for (int i = 0; i < 4; i++) begin
                    if (!done_mask[i]) begin
                        shift_data[4*i +: 4] = {data_q[4*i +: 3], 1'b0};
                        shift_cnt[4*i +: 4]  = cnt_q[4*i +: 4] + 4'd1;
                    end
                end
            end
            LANE8: begin
                for (int i = 0; i < 2; i++) begin
                    if (!done_mask[i]) begin
                        shift_data[8*i +: 8] = {data_q[8*i +: 7], 1'b0};
                        shift_cnt[8*i +: 8]  = cnt_q[8*i +: 8] + 8'd1;
                    end
                end
            end
            default: begin
                if (!done_mask[0]) begin
                    shift_data = {data_q[14:0], 1'b0};
                    shift_cnt  = cnt_q + 16'd1;
                end
            end
        endcase
    end

    // Next-state and working-register update.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = datain;
                    cnt_d   = '0;
                    mode_d  = decode_mode(bitnum);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (all_done) begin
                    state_d = ST_DONE;
                end else begin
                    data_d = shift_data;
                    cnt_d  = shift_cnt;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and working registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= LANE16;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign dataout   = data_q;
    assign shcnt     = cnt_q;

endmodule
